// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types for the CAM request controller
package cam_pkg;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_READ       = 2'b01,
    OP_SEARCH     = 2'b10,
    OP_INVALIDATE = 2'b11
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-index priority encoder over the CAM hit vector
module cam_prio_enc #(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] hits_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             multi_o
);

  logic [DEPTH-1:0] hits_m1;

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hits_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hits_m1 = hits_i - {{(DEPTH-1){1'b0}}, 1'b1};
    any_o   = |hits_i;
    multi_o = |(hits_i & hits_m1);
  end

endmodule

// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - CAM request controller: IDLE/ISSUE/RESP sequencing, valid bitmap, response regs
// Optional CAM_CTRL_MULTIHIT_EN adds rsp_multi_o flagging SEARCHes with two or more valid hits.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
`ifdef CAM_CTRL_MULTIHIT_EN
  output logic                   rsp_multi_o,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [IDX_W-1:0]       req_addr_i,
  input  logic [WIDTH-1:0]       req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [IDX_W-1:0]       rsp_idx_o,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic [DEPTH-1:0]       cell_wr_en_o,
  output logic [DEPTH-1:0]       cell_rd_en_o,
  output logic [DEPTH-1:0]       cell_srch_o,
  output logic [WIDTH-1:0]       cell_wdata_o,
  output logic [WIDTH-1:0]       cell_key_o,
  input  logic [DEPTH-1:0]       cell_match_i,
  input  logic [DEPTH-1:0]       cell_rd_vld_i,
  input  logic [DEPTH*WIDTH-1:0] cell_rd_data_i
);

  cam_state_e       state_q, state_d;
  cam_op_e          op_q, op_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_multi_q, rsp_multi_d;

  logic             in_range;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] hits;
  logic [WIDTH-1:0] rd_data;
  logic             enc_any;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_multi;

  // Out-of-range addresses (non-power-of-2 DEPTH) select no entry at all.
  always_comb begin
    in_range = {1'b0, addr_q} < (IDX_W+1)'(DEPTH);
    sel      = in_range ? ({{(DEPTH-1){1'b0}}, 1'b1} << addr_q) : '0;
    hits     = cell_match_i & valid_q;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i] && cell_rd_vld_i[i]) begin
        rd_data = cell_rd_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  cam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
    .hits_i  (hits),
    .any_o   (enc_any),
    .idx_o   (enc_idx),
    .multi_o (enc_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
      rsp_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_multi_q <= rsp_multi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid_i) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_data_d  = rsp_data_q;
    rsp_multi_d = rsp_multi_q;
    if (state_q == ST_IDLE && req_valid_i) begin
      op_d   = cam_op_e'(req_op_i);
      addr_d = req_addr_i;
      data_d = req_data_i;
    end
    // Valid-bitmap updates commit at the end of ISSUE, so a following SEARCH sees them.
    if (state_q == ST_ISSUE) begin
      rsp_hit_d   = in_range;
      rsp_idx_d   = addr_q;
      rsp_data_d  = '0;
      rsp_multi_d = 1'b0;
      case (op_q)
        OP_WRITE:      valid_d = valid_q | sel;
        OP_READ: begin
          rsp_hit_d  = |(valid_q & sel);
          rsp_data_d = rd_data;
        end
        OP_SEARCH: begin
          rsp_hit_d   = enc_any;
          rsp_idx_d   = enc_idx;
          rsp_multi_d = enc_multi;
        end
        OP_INVALIDATE: valid_d = valid_q & ~sel;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o  = (state_q == ST_IDLE);
    rsp_valid_o  = (state_q == ST_RESP);
    cell_wr_en_o = '0;
    cell_rd_en_o = '0;
    cell_srch_o  = '0;
    if (state_q == ST_ISSUE) begin
      cell_wr_en_o = (op_q == OP_WRITE)  ? sel : '0;
      cell_rd_en_o = (op_q == OP_READ)   ? sel : '0;
      cell_srch_o  = (op_q == OP_SEARCH) ? '1  : '0;
    end
  end

  assign cell_wdata_o = data_q;
  assign cell_key_o   = data_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_idx_o    = rsp_idx_q;
  assign rsp_data_o   = rsp_data_q;

`ifdef CAM_CTRL_MULTIHIT_EN
  assign rsp_multi_o = rsp_multi_q;
`else
  logic unused_multi;
  assign unused_multi = rsp_multi_q;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - self-checking bench for cam_ctrl with a behavioural cell array and reference model
module tb_cam_ctrl;

  localparam int D = 12;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_op = 2'b00;
  logic [3:0]     req_addr = '0;
  logic [W-1:0]   req_data = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_hit;
  logic [3:0]     rsp_idx;
  logic [W-1:0]   rsp_data;
  logic [D-1:0]   cell_wr_en, cell_rd_en, cell_srch;
  logic [W-1:0]   cell_wdata, cell_key;
  logic [D-1:0]   cell_match, cell_rd_vld;
  logic [D*W-1:0] cell_rd_data;
`ifdef CAM_CTRL_MULTIHIT_EN
  logic           rsp_multi;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cam_ctrl #(.DEPTH(D), .WIDTH(W)) dut (
`ifdef CAM_CTRL_MULTIHIT_EN
    .rsp_multi_o    (rsp_multi),
`endif
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_hit_o      (rsp_hit),
    .rsp_idx_o      (rsp_idx),
    .rsp_data_o     (rsp_data),
    .cell_wr_en_o   (cell_wr_en),
    .cell_rd_en_o   (cell_rd_en),
    .cell_srch_o    (cell_srch),
    .cell_wdata_o   (cell_wdata),
    .cell_key_o     (cell_key),
    .cell_match_i   (cell_match),
    .cell_rd_vld_i  (cell_rd_vld),
    .cell_rd_data_i (cell_rd_data)
  );

  // Cell array environment: storage that is cleared by reset and matches combinationally.
  logic [W-1:0] cell_mem [D];
  always @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (rst) cell_mem[i] <= '0;
      else if (cell_wr_en[i]) cell_mem[i] <= cell_wdata;
    end
  end
  always_comb begin
    cell_match   = '0;
    cell_rd_vld  = '0;
    cell_rd_data = '0;
    for (int i = 0; i < D; i++) begin
      cell_match[i]  = cell_srch[i] && (cell_mem[i] == cell_key);
      cell_rd_vld[i] = cell_rd_en[i];
      if (cell_rd_en[i]) cell_rd_data[i*W +: W] = cell_mem[i];
    end
  end

  // Reference model: what each entry holds and whether it is valid.
  bit           ref_valid [D];
  logic [W-1:0] ref_data  [D];

  function automatic void model_clear();
    for (int i = 0; i < D; i++) begin
      ref_valid[i] = 1'b0;
      ref_data[i]  = '0;
    end
  endfunction

  function automatic void model_exec(input logic [1:0] op, input logic [3:0] addr, input logic [W-1:0] d,
                                     output logic hit, output logic [3:0] idx, output logic [W-1:0] data,
                                     output logic multi, output logic [D-1:0] wr, output logic [D-1:0] rd,
                                     output logic [D-1:0] srch);
    int nh;
    bit inr;
    inr = (int'(addr) < D);
    hit = 1'b0; idx = addr; data = '0; multi = 1'b0; wr = '0; rd = '0; srch = '0;
    case (op)
      2'd0: if (inr) begin ref_valid[addr] = 1'b1; ref_data[addr] = d; hit = 1'b1; wr[addr] = 1'b1; end
      2'd1: if (inr) begin hit = ref_valid[addr]; data = ref_data[addr]; rd[addr] = 1'b1; end
      2'd2: begin
        srch = '1;
        idx = '0;
        nh = 0;
        for (int i = D - 1; i >= 0; i--) begin
          if (ref_valid[i] && ref_data[i] == d) begin idx = 4'(i); nh++; end
        end
        hit = (nh > 0);
        multi = (nh > 1);
      end
      default: if (inr) begin ref_valid[addr] = 1'b0; hit = 1'b1; end
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  // Accept a request, record the ISSUE-cycle enables, stop at the first negedge of RESP.
  task automatic send_req(input logic [1:0] op, input logic [3:0] addr, input logic [W-1:0] d,
                          output bit lat_ok, output logic [D-1:0] wr, output logic [D-1:0] rd,
                          output logic [D-1:0] srch);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = d;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat_ok = (cnt < 50) && (rsp_valid === 1'b0);
    wr = cell_wr_en; rd = cell_rd_en; srch = cell_srch;
    @(negedge clk);
    if (rsp_valid !== 1'b1) lat_ok = 1'b0;
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
  endtask

  task automatic take_rsp(output logic hit, output logic [3:0] idx, output logic [W-1:0] data, output logic multi);
    hit = rsp_hit; idx = rsp_idx; data = rsp_data;
`ifdef CAM_CTRL_MULTIHIT_EN
    multi = rsp_multi;
`else
    multi = 1'b0;
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rsp_valid, rsp_hit, rsp_idx, rsp_data} !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b h=%b i=%0d d=%h exp all 0", rsp_valid, rsp_hit, rsp_idx, rsp_data);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    checks++;
    if ({cell_wr_en, cell_rd_en, cell_srch} !== '0) begin
      errors++; $display("FAIL reset_enables: got wr=%h rd=%h s=%h exp 0", cell_wr_en, cell_rd_en, cell_srch);
    end
  endtask

  task automatic test_empty_search();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    send_req(2'd2, 4'd0, 32'h0, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b0 || i !== 4'd0) begin errors++; $display("FAIL empty_search: got hit=%b idx=%0d exp hit=0 idx=0", h, i); end
    checks++;
    if (sr !== '1) begin errors++; $display("FAIL empty_search_srch_en: got %h exp %h", sr, {D{1'b1}}); end
  endtask

  task automatic test_write_search();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    send_req(2'd0, 4'd3, 32'hDEADBEEF, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (wr !== 12'h008 || h !== 1'b1) begin errors++; $display("FAIL write3: got wr=%h hit=%b exp wr=008 hit=1", wr, h); end
    send_req(2'd2, 4'd0, 32'hDEADBEEF, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (lat !== 1'b1) begin errors++; $display("FAIL search_latency: got lat_ok=%b exp 1", lat); end
    checks++;
    if (h !== 1'b1 || i !== 4'd3) begin errors++; $display("FAIL search_dead: got hit=%b idx=%0d exp hit=1 idx=3", h, i); end
  endtask

  task automatic test_multi();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    send_req(2'd0, 4'd9, 32'h55, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    send_req(2'd0, 4'd5, 32'h55, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    send_req(2'd2, 4'd0, 32'h55, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b1 || i !== 4'd5) begin errors++; $display("FAIL multi_lowest: got hit=%b idx=%0d exp hit=1 idx=5", h, i); end
`ifdef CAM_CTRL_MULTIHIT_EN
    checks++;
    if (m !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b exp 1", m); end
`endif
  endtask

  task automatic test_read_inv();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    send_req(2'd1, 4'd3, 32'h0, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (d !== 32'hDEADBEEF || h !== 1'b1 || rd !== 12'h008) begin
      errors++; $display("FAIL read3: got d=%h hit=%b rd=%h exp d=deadbeef hit=1 rd=008", d, h, rd);
    end
    send_req(2'd3, 4'd3, 32'h0, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if ({wr, rd, sr} !== '0 || h !== 1'b1) begin errors++; $display("FAIL inv3: got en=%h hit=%b exp en=0 hit=1", {wr, rd, sr}, h); end
    send_req(2'd1, 4'd3, 32'h0, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL read3_after_inv: got hit=%b exp 0", h); end
    send_req(2'd2, 4'd0, 32'hDEADBEEF, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL search_after_inv: got hit=%b exp 0", h); end
  endtask

  task automatic test_out_of_range();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    send_req(2'd0, 4'd14, 32'h77, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (wr !== '0 || h !== 1'b0 || i !== 4'd14) begin
      errors++; $display("FAIL oor_write: got wr=%h hit=%b idx=%0d exp wr=0 hit=0 idx=14", wr, h, i);
    end
    send_req(2'd2, 4'd0, 32'h77, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL oor_search: got hit=%b exp 0", h); end
  endtask

  task automatic test_stall();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    bit stable;
    send_req(2'd0, 4'd7, 32'h1234, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    send_req(2'd1, 4'd7, 32'h0, lat, wr, rd, sr);
    stable = 1'b1;
    req_valid = 1'b1; req_op = 2'd3; req_addr = 4'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_hit !== 1'b1 || rsp_data !== 32'h1234 || rsp_idx !== 4'd7)
        stable = 1'b0;
    end
    req_valid = 1'b0;
    take_rsp(h, i, d, m);
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got stable=%b exp 1", stable); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_no_accept: got rsp_valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    send_req(2'd1, 4'd7, 32'h0, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL stall_entry_kept: got hit=%b exp 1", h); end
  endtask

  task automatic test_reset_issue();
    bit lat; logic [D-1:0] wr, rd, sr; logic h, m; logic [3:0] i; logic [W-1:0] d;
    bit quiet;
    int cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_addr = 4'd2; req_data = 32'hCAFE0002;
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL reset_issue_no_rsp: got quiet=%b exp 1", quiet); end
    send_req(2'd2, 4'd0, 32'hCAFE0002, lat, wr, rd, sr);
    take_rsp(h, i, d, m);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL reset_issue_search: got hit=%b exp 0", h); end
  endtask

  task automatic test_random();
    logic [W-1:0] pool [4];
    bit lat; logic [D-1:0] wr, rd, sr, ewr, erd, esr;
    logic h, m, eh, em; logic [3:0] i, ei; logic [W-1:0] d, ed;
    logic [1:0] op; logic [3:0] addr; logic [W-1:0] key;
    pool[0] = 32'h0; pool[1] = 32'h55; pool[2] = 32'hDEADBEEF; pool[3] = 32'hA5A50001;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      op   = 2'($urandom_range(0, 3));
      addr = 4'($urandom_range(0, 15));
      key  = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 3)];
      model_exec(op, addr, key, eh, ei, ed, em, ewr, erd, esr);
      send_req(op, addr, key, lat, wr, rd, sr);
      take_rsp(h, i, d, m);
      checks++;
      if (lat !== 1'b1) begin errors++; $display("FAIL rnd%0d_latency: got %b exp 1", n, lat); end
      checks++;
      if ({wr, rd, sr} !== {ewr, erd, esr}) begin
        errors++; $display("FAIL rnd%0d_enables op=%0d a=%0d: got %h/%h/%h exp %h/%h/%h", n, op, addr, wr, rd, sr, ewr, erd, esr);
      end
      checks++;
      if (h !== eh || i !== ei || d !== ed) begin
        errors++; $display("FAIL rnd%0d_rsp op=%0d a=%0d k=%h: got h=%b i=%0d d=%h exp h=%b i=%0d d=%h", n, op, addr, key, h, i, d, eh, ei, ed);
      end
`ifdef CAM_CTRL_MULTIHIT_EN
      checks++;
      if (m !== em) begin errors++; $display("FAIL rnd%0d_multi: got %b exp %b", n, m, em); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_empty_search();
    test_write_search();
    test_multi();
    test_read_inv();
    test_out_of_range();
    test_stall();
    test_reset_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
